// File: rtl/uart_defs.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
// Also imported by the transmitter and the comm byte assembler.
package uart_defs;

  localparam int DBIT_D    = 8;
  localparam int OS_D      = 16;
  localparam int SB_TICK_D = 16;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable
// so idle-high lines do not glitch low out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 oversampling UART receiver with a one-deep holding register,
// valid/ack handshake, and framing-error / overrun / line-break reporting.
module uart_rx_os
  import uart_defs::*;
#(
  parameter int DBIT    = DBIT_D,
  parameter int OS      = OS_D,
  parameter int SB_TICK = SB_TICK_D
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            rx_ack,
  output logic [DBIT-1:0] d_out,
  output logic            rx_valid,
  output logic            rx_done_flag,
  output logic            frame_err,
  output logic            overrun,
  output logic            line_break
);

  localparam int SMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            rxs;
  logic [2:0]      state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

  assign line_break = (state == BREAK);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      d_out        <= '0;
      rx_valid     <= 1'b0;
      rx_done_flag <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rx_done_flag <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      if (rx_ack && rx_valid) rx_valid <= 1'b0;

      case (state)
        IDLE:
          if (!rxs) begin
            state <= START;
            s     <= '0;
          end
        START:
          if (s_tick) begin
            if (s == S_HALF) begin
              // Re-check mid start bit; a short low pulse is dropped silently.
              if (!rxs) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        DATA:
          if (s_tick) begin
            if (s == S_BIT) begin
              b <= {rxs, b[DBIT-1:1]};
              s <= '0;
              if (n == N_LAST) state <= STOP;
              else             n     <= n + 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end
        STOP:
          if (s_tick) begin
            if (s == S_STOP) begin
              if (rxs) begin
                // A same-cycle ack consumes the old byte, so no overrun then.
                state        <= IDLE;
                d_out        <= b;
                rx_valid     <= 1'b1;
                rx_done_flag <= 1'b1;
                overrun      <= rx_valid && !rx_ack;
              end else begin
                frame_err <= 1'b1;
                state     <= (b == '0) ? BREAK : IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        BREAK:
          if (s_tick && rxs) state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Oversampling UART receiver directly upstream of the comm byte assembler.
- Recovers 8N1 frames from the serial line using the 16x-baud tick from sample_ticker.
- Presents each received byte through a one-deep holding register with a valid/ack handshake.
- Flags framing errors, overruns and line breaks, so comm never assembles a corrupted plaintext block.

Parameters:
- DBIT, 8, data bits per frame, LSB first.
- OS, 16, s_tick pulses per bit period.
- SB_TICK, 16, s_tick pulses sampled for the stop bit (16 = 1 stop bit).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- rx  input  1  raw serial line, idle high, asynchronous to clk.
- s_tick  input  1  one-clk-wide oversampling tick from sample_ticker.
- rx_ack  input  1  consumer accepts d_out; honoured only while rx_valid=1.
- d_out  output  DBIT  last good received byte.
- rx_valid  output  1  d_out holds an unconsumed byte.
- rx_done_flag  output  1  one-cycle pulse when a good frame is written to d_out.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a good byte overwrites an unacked byte.
- line_break  output  1  level, high while the receiver is in BREAK.

Behaviour:
- Reset (reset=0, async): state=IDLE; tick count s=0; bit count n=0; shift register b=0.
  - Both synchronizer flops = 1.
  - d_out=0, rx_valid=0, rx_done_flag=0, frame_err=0, overrun=0, line_break=0.
- Synchronizer: rx passes through 2 flops; all decisions use the synced value rxs. Latency rx->rxs is 2 clk.
- All counter advances are gated by s_tick; no state changes except on s_tick, apart from IDLE start detection and the handshake.
- IDLE: rxs=0 -> START, s=0.
- START:
  - on s_tick with s==OS/2-1 (7): if rxs=0 -> DATA with s=0, n=0; if rxs=1 -> IDLE (glitch rejected, no flag).
  - Otherwise s++ on s_tick.
- DATA:
  - on s_tick with s==OS-1: b={rxs,b[DBIT-1:1]}, s=0.
  - If n==DBIT-1 -> STOP, else n++.
  - Otherwise s++ on s_tick.
  - Samples therefore fall mid-bit.
- STOP:
  - on s_tick with s==SB_TICK-1:
    - rxs=1: good frame -> IDLE. Same edge: d_out<=b, rx_valid<=1, rx_done_flag pulses.
    - rxs=0: frame_err pulses, b discarded, d_out/rx_valid untouched. If b==0 also -> BREAK, else -> IDLE.
- BREAK: line_break=1; on rxs=1 -> IDLE. No start detection while in BREAK.
- Handshake:
  - rx_ack while rx_valid=1 clears rx_valid next edge.
  - rx_ack while rx_valid=0 is ignored.
- Overrun (good frame while rx_valid=1 and no rx_ack that cycle):
  - d_out takes the new byte, rx_valid stays 1, overrun pulses.
- Simultaneous good frame and rx_ack: d_out new, rx_valid stays 1, no overrun.
- Every pulse output is exactly one clk wide and registered.
- Reset asserted mid-frame: everything returns to reset values immediately; the partial byte is lost. After release the receiver waits in IDLE for the next falling edge.
- rx low at reset release: START is entered after the 2-clk sync latency. It is treated as a normal start; a held-low line ends in frame_err then BREAK.

Decomposition:
- Shared package/include (uart_defs):
  - state encoding localparams IDLE=0, START=1, DATA=2, STOP=3, BREAK=4 (3 bits).
  - default DBIT/OS/SB_TICK.
  - reused by UART_tx and comm.
- Sub-module sync_2ff (1-bit, reset value parameter, async active-low reset on clk/reset). It is also reusable for other asynchronous inputs.
- The FSM, counters and holding register stay in uart_rx_os.

Test Plan:
- Frame 8'hA5 (start, bits LSB first, stop, 16 ticks/bit) -> exactly one rx_done_flag; d_out=8'hA5, rx_valid=1; frame_err=0; no other pulses.
- Bytes 8'h00..8'hFF step 8'h11 back-to-back, rx_ack one cycle after each rx_done_flag -> 16 bytes recovered in order, no overrun; mirrors a full 128-bit plaintext load into comm.
- rx low for 5 ticks then high (glitch) -> back to IDLE, no pulses. Following frame 8'h3C -> d_out=8'h3C.
- Frame 8'h5A with stop bit low -> frame_err pulse, d_out/rx_valid unchanged; next frame 8'h81 -> d_out=8'h81.
- Line held low for 30 bit periods -> frame_err once, line_break=1 until line high, then frame 8'h7E -> d_out=8'h7E.
- Frames 8'h12 then 8'h34 with no rx_ack -> overrun pulse, d_out=8'h34, rx_valid=1.
- Reset pulsed low mid-DATA -> all outputs 0; next full frame 8'hC3 received correctly.
